apb_cmd_master: RTL and testbench

Parametrised APB4 requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns one response per command on a valid/ready response stream. It generalises the team's fixed 4-bit-address, 16-bit-data master with several additions: configurable widths, byte strobes, PSLVERR capture, a wait-state timeout, back-to-back transfers and response backpressure. It sits between a local controller (CPU bridge or DMA sequencer) and an APB slave or decoder.

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_wait_timer.sv | 35 +++
 rtl/apb_cmd_master.sv | 126 ++++++++++++
 tb/tb_apb_cmd_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB command master: FSM encoding, response record and
// strobe-width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_STRB_W = PKG_DATA_W / 8;

  // Response record at the default data width; width-generic users build the
  // same layout from their own DATA_W.
  typedef struct packed {
    logic [PKG_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low and flags the cycle on which the
// transfer must be abandoned. Disappears entirely when TIMEOUT is 0.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at LAST so a stalled abort can never wrap back to zero.
    always_ff @(posedge pclk) begin
      if (preset || clear) begin
        cnt_q <= '0;
      end else if (count_en && (cnt_q != LAST)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign expired = count_en && (cnt_q == LAST);
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns one response per command, with PSLVERR capture and wait timeout.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int STRB_W = strb_w(DATA_W)
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_w_t;

  state_t state_q, state_d;

  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  rsp_w_t            rsp_q;
  logic              rsp_valid_q;

  logic slot_free, accept, done, count_en, clear, expired;

  // A new command may only be taken when its response has somewhere to go.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign cmd_ready = !preset && slot_free &&
                     ((state_q == IDLE) || ((state_q == ACCESS) && pready));
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state_q == ACCESS) && pready;
  assign count_en  = (state_q == ACCESS) && !pready;
  assign clear     = (state_d == SETUP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (pready)       state_d = accept ? SETUP : IDLE;
        else if (expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk     (pclk),
    .preset   (preset),
    .clear    (clear),
    .count_en (count_en),
    .expired  (expired)
  );

  // Command capture: held stable for the whole SETUP/ACCESS pair.
  always_ff @(posedge pclk) begin
    if (accept) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      strb_q  <= cmd_strb;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset)                rsp_valid_q <= 1'b0;
    else if (done || expired)  rsp_valid_q <= 1'b1;
    else if (rsp_ready)        rsp_valid_q <= 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (done) begin
      rsp_q <= '{rdata: (write_q ? '0 : prdata), err: pslverr, timeout: 1'b0};
    end else if (expired) begin
      rsp_q <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
    end
  end

  // Response fields read as zero whenever no response is held.
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_valid_q ? rsp_q.rdata : '0;
  assign rsp_err     = rsp_valid_q && rsp_q.err;
  assign rsp_timeout = rsp_valid_q && rsp_q.timeout;

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign pwrite  = psel && write_q;
  assign paddr   = psel ? addr_q : '0;
  assign pwdata  = pwrite ? wdata_q : '0;
  assign pstrb   = pwrite ? strb_q : '0;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a transaction-level reference model.
module tb_apb_cmd_master;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int T      = 4;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic              preset, cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr, paddr;
  logic [DATA_W-1:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  logic [STRB_W-1:0] cmd_strb, pstrb;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic              psel, penable, pwrite, pready, pslverr;

  apb_cmd_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (T)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pready      (pready),
    .pslverr     (pslverr),
    .prdata      (prdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transfer in flight, aged in cycles since its accept
  // edge (age 1 = SETUP, age >= 2 = ACCESS), plus a single response slot.
  bit              cmp_on = 1'b0;
  bit              m_busy = 1'b0;
  int              m_age = 0;
  int              m_waits = 0;
  bit              m_write = 1'b0;
  logic [7:0]      m_addr = '0;
  logic [31:0]     m_wdata = '0;
  logic [3:0]      m_strb = '0;
  bit              m_rv = 1'b0;
  logic [31:0]     m_rd = '0;
  bit              m_err = 1'b0;
  bit              m_to = 1'b0;
  bit              c_acc_phase, c_rdy, c_take, c_done, c_abort;

  always @(negedge pclk) begin
    #3;
    if (cmp_on) begin
      c_acc_phase = m_busy && (m_age >= 2);
      c_rdy = !preset && (!m_rv || rsp_ready) && (!m_busy || (c_acc_phase && pready));
      check("cmd_ready", cmd_ready, c_rdy);
      check("psel", psel, m_busy);
      check("penable", penable, c_acc_phase);
      check("pwrite", pwrite, m_busy && m_write);
      check("paddr", paddr, m_busy ? m_addr : 8'h0);
      check("pwdata", pwdata, (m_busy && m_write) ? m_wdata : 32'h0);
      check("pstrb", pstrb, (m_busy && m_write) ? m_strb : 4'h0);
      check("rsp_valid", rsp_valid, m_rv);
      check("rsp_rdata", rsp_rdata, m_rv ? m_rd : 32'h0);
      check("rsp_err", rsp_err, m_rv && m_err);
      check("rsp_timeout", rsp_timeout, m_rv && m_to);

      c_take  = cmd_valid && c_rdy;
      c_done  = c_acc_phase && pready;
      c_abort = c_acc_phase && !pready && (m_waits + 1 == T);
      if (preset) begin
        m_busy = 1'b0;
        m_rv   = 1'b0;
      end else begin
        if (c_done) begin
          m_rv = 1'b1; m_rd = m_write ? 32'h0 : prdata; m_err = pslverr; m_to = 1'b0;
        end else if (c_abort) begin
          m_rv = 1'b1; m_rd = 32'h0; m_err = 1'b1; m_to = 1'b1;
        end else if (rsp_ready) begin
          m_rv = 1'b0;
        end
        if (c_take) begin
          m_busy = 1'b1; m_age = 1; m_waits = 0;
          m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata; m_strb = cmd_strb;
        end else if (c_done || c_abort) begin
          m_busy = 1'b0;
        end else if (m_busy) begin
          if (c_acc_phase) m_waits++;
          m_age++;
        end
      end
    end
  end

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  task automatic put_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
  endtask

  int         n_acc;
  logic [3:0] strb_or;
  logic [3:0] psel_v, pen_v;

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0; prdata = '0;

    // Reset
    step(); cmp_on = 1'b1; smp();
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_psel", psel, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    step(); smp();

    // Zero-wait write
    step(); preset = 1'b0; put_cmd(1'b1, 8'hA5, 32'hDEADBEEF, 4'hF); smp();
    check("wr_accept", cmd_ready, 1'b1);
    step(); cmd_valid = 1'b0; smp();
    check("wr_setup_psel", psel, 1'b1);
    check("wr_setup_penable", penable, 1'b0);
    step(); smp();
    check("wr_access_penable", penable, 1'b1);
    check("wr_access_paddr", paddr, 8'hA5);
    check("wr_access_pstrb", pstrb, 4'hF);
    step(); smp();
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_err", rsp_err, 1'b0);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);

    // Read with two wait states
    step(); put_cmd(1'b0, 8'h10, 32'h0, 4'hF); pready = 1'b0; smp();
    n_acc = 0; strb_or = '0;
    step(); cmd_valid = 1'b0; smp(); strb_or |= pstrb;
    for (int i = 0; i < 3; i++) begin
      step(); pready = (i == 2); prdata = (i == 2) ? 32'h12345678 : 32'hFFFF0000; smp();
      n_acc += int'(penable); strb_or |= pstrb;
    end
    step(); pready = 1'b1; prdata = '0; smp();
    check("rd_access_cycles", n_acc, 3);
    check("rd_pstrb_zero", strb_or, 4'h0);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);

    // Back-to-back writes
    step(); put_cmd(1'b1, 8'h30, 32'h11111111, 4'h3); smp();
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) put_cmd(1'b1, 8'h31, 32'h22222222, 4'hC);
      if (i == 2) cmd_valid = 1'b0;
      smp();
      psel_v[3-i] = psel; pen_v[3-i] = penable;
      if (i == 1) check("b2b_second_accept", cmd_ready, 1'b1);
    end
    check("b2b_psel", psel_v, 4'b1111);
    check("b2b_penable", pen_v, 4'b0101);
    step(); smp();
    check("b2b_idle_psel", psel, 1'b0);

    // Read completing with PSLVERR
    step(); put_cmd(1'b0, 8'h44, 32'h0, 4'h0); pslverr = 1'b1; prdata = 32'hCAFEF00D; smp();
    step(); cmd_valid = 1'b0; smp();
    step(); smp();
    step(); smp();
    check("slverr_err", rsp_err, 1'b1);
    check("slverr_timeout", rsp_timeout, 1'b0);
    pslverr = 1'b0;

    // Wait-state timeout
    step(); pslverr = 1'b0; put_cmd(1'b0, 8'h20, 32'h0, 4'h0); pready = 1'b0; prdata = 32'h55AA55AA; smp();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(); cmd_valid = 1'b0; smp();
      n_acc += int'(penable);
    end
    check("to_access_cycles", n_acc, 4);
    check("to_psel_low", psel, 1'b0);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_timeout", rsp_timeout, 1'b1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    pready = 1'b1; prdata = '0;

    // Response backpressure
    step(); rsp_ready = 1'b0; put_cmd(1'b1, 8'h50, 32'hA0A0A0A0, 4'h1); smp();
    check("bp_first_accept", cmd_ready, 1'b1);
    step(); cmd_valid = 1'b0; smp();
    step(); smp();
    step(); put_cmd(1'b1, 8'h51, 32'hB0B0B0B0, 4'h2); smp();
    for (int i = 0; i < 4; i++) begin
      check("bp_cmd_ready_low", cmd_ready, 1'b0);
      check("bp_rsp_held", rsp_valid, 1'b1);
      step(); smp();
    end
    step(); rsp_ready = 1'b1; smp();
    check("bp_release_accept", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(); cmd_valid = 1'b0; smp();
    end

    // Reset during ACCESS
    step(); put_cmd(1'b0, 8'h60, 32'h0, 4'h0); pready = 1'b0; smp();
    step(); cmd_valid = 1'b0; smp();
    step(); smp();
    check("rst_mid_in_access", penable, 1'b1);
    step(); preset = 1'b1; smp();
    step(); preset = 1'b0; pready = 1'b1; smp();
    check("rst_mid_psel", psel, 1'b0);
    check("rst_mid_penable", penable, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);

    // Reset discards a held response
    step(); rsp_ready = 1'b0; put_cmd(1'b1, 8'h70, 32'h01020304, 4'hF); smp();
    step(); cmd_valid = 1'b0; smp();
    step(); smp();
    step(); smp();
    check("rst_hold_rsp_valid", rsp_valid, 1'b1);
    step(); preset = 1'b1; smp();
    step(); preset = 1'b0; smp();
    check("rst_discard_rsp_valid", rsp_valid, 1'b0);
    check("rst_discard_cmd_ready", cmd_ready, 1'b1);
    rsp_ready = 1'b1;

    step(); smp();
    step(); smp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
